// File: rtl/mul_share_pkg.sv
// -----------------------------------------------------------------------------
// mul_share_pkg
// Shared widths and types for the shared-multiplier arbiter slice.
//   OP_W    : operand width (signed)
//   PROD_W  : full-precision product width
//   CNT_W   : width of each optional per-requester grant counter
//   operand_t / product_t : signed operand and product types
// -----------------------------------------------------------------------------
package mul_share_pkg;

  localparam int OP_W   = 24;
  localparam int PROD_W = 48;
  localparam int CNT_W  = 16;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef logic signed [OP_W-1:0]   operand_t;
  typedef logic signed [PROD_W-1:0] product_t;

endpackage

// File: rtl/mul24.sv
// -----------------------------------------------------------------------------
// mul24
// Purely combinational 24x24 signed multiplier with a full 48-bit result.
// Ports:
//   a   : signed operand A
//   b   : signed operand B
//   out : signed product a*b, full precision, no saturation
// -----------------------------------------------------------------------------
module mul24
  import mul_share_pkg::*;
(
  input  operand_t a,
  input  operand_t b,
  output product_t out
);

  // Both operands are widened to the product width before multiplying so the
  // result keeps every bit, including -2^23 * -2^23 = 2^46.
  assign out = product_t'(a) * product_t'(b);

endmodule

// File: rtl/mul_share_arb.sv
// -----------------------------------------------------------------------------
// mul_share_arb
// NREQ requesters share one 24x24 signed multiplier through a round-robin
// arbiter and a two-stage pipeline (S1: operands + id, S2: product + id).
// Ports:
//   clk, rst_n            : clock (rising edge), async active-low reset
//   req_valid / req_ready : per-requester handshake, at most one ready bit high
//   req_a / req_b         : packed signed operands, requester i at [24*i +: 24]
//   rsp_valid / rsp_ready : product handshake
//   rsp_data / rsp_id     : signed product and issuing requester index
//   busy                  : any pipeline stage holds an entry
//   grant_cnt             : per-requester saturating transfer counters, only
//                           present when MUL_SHARE_ARB_STATS_EN is defined
// -----------------------------------------------------------------------------
module mul_share_arb
  import mul_share_pkg::*;
#(
  parameter  int NREQ = 2,
  localparam int ID_W = $clog2(NREQ)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NREQ-1:0]        req_valid,
  output logic [NREQ-1:0]        req_ready,
  input  logic [NREQ*OP_W-1:0]   req_a,
  input  logic [NREQ*OP_W-1:0]   req_b,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [PROD_W-1:0]      rsp_data,
  output logic [ID_W-1:0]        rsp_id,
  output logic                   busy
`ifdef MUL_SHARE_ARB_STATS_EN
  ,
  output logic [NREQ*CNT_W-1:0]  grant_cnt
`endif
);

  // Pipeline state
  logic            s1Valid_q;
  operand_t        s1A_q, s1B_q;
  logic [ID_W-1:0] s1Id_q;
  logic            s2Valid_q;
  product_t        s2Data_q;
  logic [ID_W-1:0] s2Id_q;

  // Arbitration state
  logic [ID_W-1:0] ptr_q, ptr_d;
  logic [ID_W-1:0] grantIdx, hiIdx, anyIdx;
  logic            foundHi;
  logic            anyValid;

  logic            s2Load;
  logic            canAccept;
  logic            reqXfer;
  logic [NREQ-1:0] reqReady;
  operand_t        selA, selB;
  product_t        product;

  // S2 frees up when empty or draining; S1 can take a new entry whenever it
  // is empty or moving into S2 in the same cycle.
  assign s2Load    = !s2Valid_q || rsp_ready;
  assign canAccept = !s1Valid_q || s2Load;
  assign anyValid  = |req_valid;

  // Round-robin pick: the lowest valid index at or above ptr wins; if none
  // exists the search wraps and the lowest valid index overall wins. Walking
  // downward leaves the lowest candidate in each register.
  always_comb begin
    hiIdx   = '0;
    anyIdx  = '0;
    foundHi = 1'b0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (req_valid[i]) begin
        anyIdx = ID_W'(i);
        if (i >= int'(ptr_q)) begin
          hiIdx   = ID_W'(i);
          foundHi = 1'b1;
        end
      end
    end
    grantIdx = foundHi ? hiIdx : anyIdx;
  end

  // Ready is a one-hot of the grant, suppressed while in reset so nothing can
  // look accepted before the pipeline is live.
  always_comb begin
    reqReady = '0;
    if (rst_n && canAccept && anyValid) begin
      reqReady[grantIdx] = 1'b1;
    end
  end

  assign req_ready = reqReady;
  assign reqXfer   = |(req_valid & reqReady);

  // Operand mux for the granted requester
  always_comb begin
    selA = req_a[OP_W*grantIdx +: OP_W];
    selB = req_b[OP_W*grantIdx +: OP_W];
  end

  // Pointer moves past the winner only on a completed transfer
  always_comb begin
    ptr_d = ptr_q;
    if (reqXfer) begin
      ptr_d = (grantIdx == ID_W'(NREQ - 1)) ? '0 : grantIdx + 1'b1;
    end
  end

  mul24 u_mul24 (
    .a   (s1A_q),
    .b   (s1B_q),
    .out (product)
  );

  // Two pipeline stages plus the arbitration pointer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1Valid_q <= 1'b0;
      s1A_q     <= '0;
      s1B_q     <= '0;
      s1Id_q    <= '0;
      s2Valid_q <= 1'b0;
      s2Data_q  <= '0;
      s2Id_q    <= '0;
      ptr_q     <= '0;
    end else begin
      ptr_q <= ptr_d;
      if (s2Load) begin
        s2Valid_q <= s1Valid_q;
        if (s1Valid_q) begin
          s2Data_q <= product;
          s2Id_q   <= s1Id_q;
        end
      end
      if (reqXfer) begin
        s1Valid_q <= 1'b1;
        s1A_q     <= selA;
        s1B_q     <= selB;
        s1Id_q    <= grantIdx;
      end else if (s2Load) begin
        s1Valid_q <= 1'b0;
      end
    end
  end

  assign rsp_valid = s2Valid_q;
  assign rsp_data  = s2Data_q;
  assign rsp_id    = s2Id_q;
  assign busy      = s1Valid_q || s2Valid_q;

`ifdef MUL_SHARE_ARB_STATS_EN
  logic [CNT_W-1:0] grantCnt_q [NREQ];

  // Per-requester transfer counters that stick at their maximum
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREQ; i++) begin
        grantCnt_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NREQ; i++) begin
        if (reqXfer && (grantIdx == ID_W'(i)) && (grantCnt_q[i] != CNT_MAX)) begin
          grantCnt_q[i] <= grantCnt_q[i] + 1'b1;
        end
      end
    end
  end

  always_comb begin
    grant_cnt = '0;
    for (int i = 0; i < NREQ; i++) begin
      grant_cnt[CNT_W*i +: CNT_W] = grantCnt_q[i];
    end
  end
`endif

endmodule
